// File: rtl/cpu_ram_copier.sv
// Avalon-MM master that copies a block of 32-bit words between two regions of a RAM,
// one read/write pair at a time, and reports a wrap-around sum of the copied words.
module cpu_ram_copier #(
  parameter int ADDR_W       = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [2:0]        lat_q, lat_d;

  logic              busy_d, done_d, cs_d, read_d, write_d;
  logic [31:0]       checksum_d, wdata_d;
  logic [ADDR_W-1:0] addr_d;

  // NOTE: every signal gets its hold value first so no path through the case leaves
  // one unassigned; that keeps this block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    lat_d      = lat_q;
    busy_d     = busy;
    done_d     = done;
    cs_d       = avm_chipselect;
    read_d     = avm_read;
    write_d    = avm_write;
    addr_d     = avm_address;
    wdata_d    = avm_writedata;
    checksum_d = checksum;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          rem_d      = length;
          checksum_d = '0;
          busy_d     = 1'b1;
          if (length == '0) begin
            state_d = FIN;
          end else begin
            state_d = RD_REQ;
            read_d  = 1'b1;
            cs_d    = 1'b1;
            addr_d  = src_addr;
          end
        end
      end

      RD_REQ: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          cs_d    = 1'b0;
          lat_d   = LAT_LOAD;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (lat_q == 3'd0) begin
          wdata_d    = avm_readdata;
          checksum_d = checksum + avm_readdata;
          write_d    = 1'b1;
          cs_d       = 1'b1;
          addr_d     = dst_q;
          state_d    = WR_REQ;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      WR_REQ: begin
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          cs_d    = 1'b0;
          src_d   = src_q + ADDR_W'(1);
          dst_d   = dst_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
            read_d  = 1'b1;
            cs_d    = 1'b1;
            addr_d  = src_q + ADDR_W'(1);
          end
        end
      end

      FIN: begin
        // An empty run arrives here with busy still high and raises done on its own.
        if (!done) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      rem_q          <= '0;
      lat_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      checksum       <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'h0;
      avm_writedata  <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      rem_q          <= rem_d;
      lat_q          <= lat_d;
      busy           <= busy_d;
      done           <= done_d;
      checksum       <= checksum_d;
      avm_address    <= addr_d;
      avm_chipselect <= cs_d;
      avm_read       <= read_d;
      avm_write      <= write_d;
      avm_byteenable <= cs_d ? 4'hF : 4'h0;
      avm_writedata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_ram_copier.sv
// Bench for cpu_ram_copier: behavioural RAM slave with optional stalls, a copy-level
// reference model feeding a scoreboard, and a monitor that checks bus traffic and done.
module tb_cpu_ram_copier;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] src_addr, dst_addr;
  logic [11:0] length;
  logic        busy, done;
  logic [31:0] checksum;
  logic [10:0] avm_address;
  logic        avm_chipselect, avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;

  cpu_ram_copier #(.ADDR_W(11), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .checksum(checksum),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] ram    [2048];
  logic [31:0] shadow [2048];
  wr_t         exp_wr_q [$];
  logic [31:0] exp_sum_q [$];

  int errors = 0;
  int checks = 0;
  int cs_cnt = 0;
  bit stall_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a plain ascending word copy over a snapshot of the RAM.
  task automatic model_push(input logic [10:0] s, input logic [10:0] d, input logic [11:0] n);
    logic [31:0] sum;
    logic [10:0] a, b;
    wr_t w;
    sum = 0;
    for (int i = 0; i < 2048; i++) shadow[i] = ram[i];
    for (int i = 0; i < int'(n); i++) begin
      a = s + 11'(i);
      b = d + 11'(i);
      shadow[b] = shadow[a];
      w.addr = b;
      w.data = shadow[b];
      exp_wr_q.push_back(w);
      sum += shadow[b];
    end
    exp_sum_q.push_back(sum);
  endtask

  // RAM slave: one cycle read latency, writes commit on acceptance.
  initial begin
    bit          rd_pend;
    logic [31:0] rd_data;
    rd_pend = 1'b0;
    rd_data = '0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      avm_readdata = rd_pend ? rd_data : $urandom;
      rd_pend = 1'b0;
      avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (avm_chipselect && avm_read && !avm_waitrequest) begin
        rd_pend = 1'b1;
        rd_data = ram[avm_address];
      end
      if (avm_chipselect && avm_write && !avm_waitrequest) ram[avm_address] = avm_writedata;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          prev_stall;
    logic [45:0] prev_req;
    wr_t         w;
    logic [31:0] e;
    prev_stall = 1'b0;
    prev_req = '0;
    forever begin
      @(negedge clk);
      if (avm_chipselect) cs_cnt++;
      check("byteenable", avm_byteenable, avm_chipselect ? 4'hF : 4'h0);
      check("rd_wr_overlap", avm_read & avm_write, 0);
      if (prev_stall)
        check("stall_hold", {avm_address, avm_read, avm_write, avm_chipselect, avm_writedata},
              prev_req);
      if (avm_chipselect && avm_write && !avm_waitrequest) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", 0, 1);
        else begin
          w = exp_wr_q.pop_front();
          check("wr_addr", avm_address, w.addr);
          check("wr_data", avm_writedata, w.data);
        end
      end
      if (done) begin
        if (exp_sum_q.size() == 0) check("unexpected_done", 0, 1);
        else begin
          e = exp_sum_q.pop_front();
          check("checksum", checksum, e);
          check("busy_low_at_done", busy, 0);
        end
      end
      prev_stall = (avm_read || avm_write) && avm_waitrequest && !reset;
      prev_req = {avm_address, avm_read, avm_write, avm_chipselect, avm_writedata};
    end
  end

  task automatic run(input logic [10:0] s, input logic [10:0] d, input logic [11:0] n,
                     input bit poke, output int busy_t, output int done_t);
    int limit;
    model_push(s, d, n);
    src_addr = s;
    dst_addr = d;
    length = n;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    busy_t = -1;
    done_t = -1;
    limit = 20 * int'(n) + 50;
    for (int t = 1; t <= limit; t++) begin
      if (poke && t == 3) begin
        src_addr = 11'd500;
        dst_addr = 11'd600;
        length = 12'd5;
        start = 1'b1;
      end
      if (poke && t == 4) start = 1'b0;
      if (busy && busy_t < 0) busy_t = t;
      if (done) begin
        done_t = t;
        break;
      end
      @(posedge clk); #2;
    end
    check("run_completes", done_t >= 0, 1);
    @(posedge clk); #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bt, dt, c0, nw;
    logic [31:0] vals [4];
    logic [10:0] s, d;

    reset = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    for (int i = 0; i < 2048; i++) ram[i] = $urandom;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {busy, done, avm_read, avm_write, avm_chipselect, avm_byteenable},
          0);
    check("reset_checksum", checksum, 0);
    check("reset_addr_data", {avm_address, avm_writedata}, 0);
    reset = 1'b0;
    @(posedge clk); #2;

    // Basic copy with timing.
    for (int i = 0; i < 4; i++) ram[i] = 32'(i + 1);
    run(11'd0, 11'd16, 12'd4, 1'b0, bt, dt);
    check("t1_busy_rise", bt, 1);
    check("t1_done_after_busy", dt - bt, 12);
    for (int i = 0; i < 4; i++) check("t1_ram", ram[16 + i], 32'(i + 1));
    check("t1_checksum", checksum, 32'd10);

    // Empty run.
    c0 = cs_cnt;
    run(11'd5, 11'd9, 12'd0, 1'b0, bt, dt);
    check("t2_busy_rise", bt, 1);
    check("t2_done_lat", dt, 2);
    check("t2_no_chipselect", cs_cnt - c0, 0);
    check("t2_checksum", checksum, 0);

    // Source address wrap.
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    ram[2046] = vals[0];
    ram[2047] = vals[1];
    ram[0] = vals[2];
    ram[1] = vals[3];
    run(11'd2046, 11'd100, 12'd4, 1'b0, bt, dt);
    for (int i = 0; i < 4; i++) check("t3_ram", ram[100 + i], vals[i]);

    // Random stalls on both reads and writes.
    stall_en = 1'b1;
    s = 11'($urandom);
    d = s + 11'd700;
    run(s, d, 12'd8, 1'b0, bt, dt);
    stall_en = 1'b0;

    // Start pulsed mid-run must be dropped.
    run(11'd200, 11'd250, 12'd8, 1'b1, bt, dt);
    repeat (10) @(posedge clk);
    #2;
    check("ignored_start_idle", busy, 0);

    // Reset during the third write.
    for (int k = 0; k < 8; k++) ram[400 + k] = 32'hDEAD_0000 + 32'(k);
    model_push(11'd300, 11'd400, 12'd8);
    src_addr = 11'd300;
    dst_addr = 11'd400;
    length = 12'd8;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    nw = 0;
    for (int t = 0; t < 200; t++) begin
      if (avm_write) nw++;
      if (nw == 3) break;
      @(posedge clk); #2;
    end
    check("t5_third_write_seen", nw, 3);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("t5_after_reset", {busy, done, avm_read, avm_write, avm_chipselect}, 0);
    exp_wr_q.delete();
    exp_sum_q.delete();
    repeat (15) @(posedge clk);
    #2;
    check("t5_stays_idle", busy, 0);
    for (int k = 0; k < 3; k++) check("t5_written", ram[400 + k], ram[300 + k]);
    for (int k = 3; k < 8; k++) check("t5_untouched", ram[400 + k], 32'hDEAD_0000 + 32'(k));
    run(11'd300, 11'd400, 12'd8, 1'b0, bt, dt);
    for (int k = 0; k < 8; k++) check("t5_rerun", ram[400 + k], ram[300 + k]);

    // Checksum wrap, then overlapping copy.
    ram[0] = 32'hFFFF_FFFF;
    ram[1] = 32'h2;
    run(11'd0, 11'd50, 12'd2, 1'b0, bt, dt);
    check("t6_checksum_wrap", checksum, 32'h1);
    vals[0] = $urandom;
    ram[0] = vals[0];
    run(11'd0, 11'd1, 12'd3, 1'b0, bt, dt);
    for (int i = 1; i <= 3; i++) check("t6_overlap", ram[i], vals[0]);

    // Random runs, then a whole-RAM copy with wrapping addresses.
    for (int r = 0; r < 4; r++) begin
      stall_en = 1'($urandom_range(0, 1));
      run(11'($urandom), 11'($urandom), 12'($urandom_range(1, 24)), 1'b0, bt, dt);
    end
    stall_en = 1'b0;
    run(11'($urandom), 11'($urandom), 12'd2048, 1'b0, bt, dt);

    repeat (5) @(posedge clk);
    #2;
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("sum_queue_drained", exp_sum_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
